gpr_sb: RTL and testbench

Parametrised general-purpose register file with two asynchronous read ports and two synchronous write ports. Port 0 is the ALU writeback and port 1 is the load/multicycle writeback. A per-register busy scoreboard tracks pending long-latency writes and raises a stall for dependent reads. Sits in the decode/writeback stage of the MIPS32 datapath.

---
 rtl/gpr_sb.sv | 124 ++++++++++++
 tb/tb_gpr_sb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_sb.sv
// gpr_sb: MIPS32 general-purpose register file.
//   - Two combinational read ports.
//   - Two write ports: port 0 is ALU writeback, port 1 is load/multicycle
//     writeback. Port 1 wins when both ports write the same address.
//   - A per-register busy scoreboard raises a stall for dependent reads.
//   - A sticky error flag records scoreboard protocol violations.
// Optional feature macro: GPR_BYPASS_EN enables same-cycle write-to-read
// forwarding, and stall then ignores busy bits cleared by we1 in that cycle.
module gpr_sb #(
  parameter int             DW      = 32,
  parameter int             AW      = 5,
  parameter logic [DW-1:0]  GP_INIT = 32'h0000_1800,
  parameter logic [DW-1:0]  SP_INIT = 32'h0000_2ffc,
  localparam int            DEPTH   = 2**AW
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [AW-1:0]    rs,
  input  logic [AW-1:0]    rt,
  input  logic             rs_rd,
  input  logic             rt_rd,
  output logic [DW-1:0]    busA,
  output logic [DW-1:0]    busB,
  output logic             eq,
  output logic             stall,
  input  logic             we0,
  input  logic [AW-1:0]    wa0,
  input  logic [DW-1:0]    wd0,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  input  logic [DW-1:0]    wd1,
  input  logic             mark,
  input  logic [AW-1:0]    mark_addr,
  output logic [DEPTH-1:0] busy,
  output logic             err
);

  logic [DEPTH-1:0][DW-1:0] regs;
  logic [DEPTH-1:0]         busy_q;
  logic [DEPTH-1:0]         busy_n;
  logic [DEPTH-1:0]         clr_mask;
  logic [DEPTH-1:0]         busy_vis;
  logic                     err_q;
  logic                     err_set;
  logic [DW-1:0]            rd_a;
  logic [DW-1:0]            rd_b;

  // Register storage. Register 0 is never written, so it keeps its reset value of 0.
  // When both ports write the same address, port 1 is assigned last and wins.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      regs <= '0;
      if (AW >= 5) begin
        regs[AW'(28)] <= GP_INIT;
        regs[AW'(29)] <= SP_INIT;
      end
    end else begin
      if (we0 && wa0 != '0) regs[wa0] <= wd0;
      if (we1 && wa1 != '0) regs[wa1] <= wd1;
    end
  end

  // Scoreboard next state: the we1 clear is applied before the mark set,
  // so a new op issued to the same register keeps it busy.
  always_comb begin
    clr_mask = '0;
    if (we1) clr_mask[wa1] = 1'b1;
    busy_n = busy_q & ~clr_mask;
    if (mark) busy_n[mark_addr] = 1'b1;
    busy_n[0] = 1'b0;
  end

  // Protocol-error detection. Register 0 is excluded from every error term.
  always_comb begin
    err_set = 1'b0;
    if (we0 && wa0 != '0 && busy_q[wa0]) err_set = 1'b1;
    if (mark && mark_addr != '0 && busy_q[mark_addr] &&
        !(we1 && wa1 == mark_addr)) err_set = 1'b1;
    if (we1 && wa1 != '0 && !busy_q[wa1]) err_set = 1'b1;
  end

  // Scoreboard and sticky error state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_n;
      err_q  <= err_q | err_set;
    end
  end

  // Read ports, with optional forwarding. Port 1 is checked last, so it has priority.
  always_comb begin
    rd_a = regs[rs];
    rd_b = regs[rt];
`ifdef GPR_BYPASS_EN
    if (we0 && wa0 == rs) rd_a = wd0;
    if (we1 && wa1 == rs) rd_a = wd1;
    if (we0 && wa0 == rt) rd_b = wd0;
    if (we1 && wa1 == rt) rd_b = wd1;
`endif
    if (rs == '0) rd_a = '0;
    if (rt == '0) rd_b = '0;
  end

  // Busy vector seen by stall. Under forwarding, bits cleared this cycle are
  // hidden, because their data is already available on the read bus.
  always_comb begin
`ifdef GPR_BYPASS_EN
    busy_vis = busy_q & ~clr_mask;
`else
    busy_vis = busy_q;
`endif
  end

  assign busA  = rd_a;
  assign busB  = rd_b;
  assign eq    = (rd_a == rd_b);
  assign stall = (rs_rd & busy_vis[rs]) | (rt_rd & busy_vis[rt]);
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_gpr_sb.sv
// tb_gpr_sb: directed self-checking bench for gpr_sb.
// Inputs are driven between clock edges; outputs are sampled 1 time unit
// after the rising edge, or shortly after the inputs change.
module tb_gpr_sb;

  logic        clk;
  logic        clr;
  logic [4:0]  rs, rt, wa0, wa1, mark_addr;
  logic        rs_rd, rt_rd, we0, we1, mark;
  logic [31:0] wd0, wd1;
  logic [31:0] busA, busB, busy;
  logic        eq, stall, err;

  int unsigned n_tests;
  int unsigned n_fail;

  gpr_sb #(.DW(32), .AW(5)) dut (
    .clk(clk), .clr(clr), .rs(rs), .rt(rt), .rs_rd(rs_rd), .rt_rd(rt_rd),
    .busA(busA), .busB(busB), .eq(eq), .stall(stall),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .mark(mark), .mark_addr(mark_addr), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    we0 = 1'b0; we1 = 1'b0; mark = 1'b0;
    wa0 = '0; wa1 = '0; mark_addr = '0; wd0 = '0; wd1 = '0;
  endtask

  task automatic pulse_clr;
    clr = 1'b1;
    #1;
    clr = 1'b0;
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clr = 1'b0;
    rs = '0; rt = '0; rs_rd = 1'b0; rt_rd = 1'b0;
    idle();

    // Reset asserted mid-cycle while a write to r5 is pending.
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hCAFE_0005;
    #1 clr = 1'b1;
    #1;
    rs = 5'd28; rt = 5'd29;
    #1;
    check("rst_gp", busA, 32'h0000_1800);
    check("rst_sp", busB, 32'h0000_2ffc);
    check("rst_busy", busy, 32'h0);
    check("rst_err", err, 1'b0);
    rs = 5'd5; rt = 5'd31;
    #1;
    check("rst_r5", busA, 32'h0);
    check("rst_r31", busB, 32'h0);
    tick();
    idle();
    clr = 1'b0;
    tick();
    check("rst_r5_after", busA, 32'h0);

    // Same-address dual write: port 1 wins. we1 to a non-busy register raises err.
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hDEAD_BEEF;
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h1234_5678;
    tick();
    idle();
    rs = 5'd3;
    #1;
    check("dual_wr_r3", busA, 32'h1234_5678);
    check("we1_idle_err", err, 1'b1);
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
    tick();
    idle();
    rs = 5'd0;
    #1;
    check("r0_reads_0", busA, 32'h0);
    // Different addresses on the two ports: both writes land.
    we0 = 1'b1; wa0 = 5'd10; wd0 = 32'h0000_0A0A;
    we1 = 1'b1; wa1 = 5'd11; wd1 = 32'h0000_0B0B;
    tick();
    idle();
    rs = 5'd10; rt = 5'd11;
    #1;
    check("dual_wr_r10", busA, 32'h0000_0A0A);
    check("dual_wr_r11", busB, 32'h0000_0B0B);
    pulse_clr();
    check("clr_err", err, 1'b0);
    rs = 5'd3;
    #1;
    check("clr_r3", busA, 32'h0);

    // Mark r8, then observe the stall, then complete it via we1.
    @(negedge clk);
    mark = 1'b1; mark_addr = 5'd8;
    tick();
    idle();
    rs = 5'd8; rs_rd = 1'b1;
    #1;
    check("mark8_busy", busy, 32'h0000_0100);
    check("mark8_stall", stall, 1'b1);
    rs_rd = 1'b0;
    #1;
    check("mark8_unused", stall, 1'b0);
    rs_rd = 1'b1;
    we1 = 1'b1; wa1 = 5'd8; wd1 = 32'h55;
    tick();
    idle();
    #1;
    check("wb8_busy", busy, 32'h0);
    check("wb8_stall", stall, 1'b0);
    check("wb8_busA", busA, 32'h55);
    check("wb8_err", err, 1'b0);
    rs_rd = 1'b0;

    // Same-edge mark and we1 on r9: r9 stays busy and no error is raised.
    mark = 1'b1; mark_addr = 5'd9;
    tick();
    mark = 1'b1; mark_addr = 5'd9;
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h77;
    tick();
    idle();
    check("reissue9_busy", busy, 32'h0000_0200);
    check("reissue9_err", err, 1'b0);
    mark = 1'b1; mark_addr = 5'd9;
    tick();
    idle();
    check("remark9_err", err, 1'b1);
    tick();
    tick();
    check("err_sticky", err, 1'b1);
    pulse_clr();
    check("err_clr", err, 1'b0);
    check("busy_clr", busy, 32'h0);

    // A we0 write to a busy register still lands, but raises err and leaves busy set.
    mark = 1'b1; mark_addr = 5'd13;
    tick();
    idle();
    we0 = 1'b1; wa0 = 5'd13; wd0 = 32'h1313;
    tick();
    idle();
    rs = 5'd13;
    #1;
    check("we0_busy_data", busA, 32'h1313);
    check("we0_busy_busy", busy, 32'h0000_2000);
    check("we0_busy_err", err, 1'b1);
    pulse_clr();

    // Marks and we1 writes addressed to r0 are ignored and never raise err.
    mark = 1'b1; mark_addr = 5'd0;
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h1;
    tick();
    idle();
    check("r0_mark_busy", busy, 32'h0);
    check("r0_err", err, 1'b0);

    // The rt read port also qualifies stall, gated by rt_rd.
    mark = 1'b1; mark_addr = 5'd12;
    tick();
    idle();
    rs = 5'd1; rs_rd = 1'b1; rt = 5'd12; rt_rd = 1'b1;
    #1;
    check("rt_stall", stall, 1'b1);
    rt_rd = 1'b0;
    #1;
    check("rt_unused", stall, 1'b0);
    rs_rd = 1'b0;
    pulse_clr();

    // Completion of a busy register while it is being read.
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h1111;
    tick();
    idle();
    mark = 1'b1; mark_addr = 5'd4;
    tick();
    idle();
    rs = 5'd4; rs_rd = 1'b1;
    we1 = 1'b1; wa1 = 5'd4; wd1 = 32'hA5A5;
    #1;
`ifdef GPR_BYPASS_EN
    check("byp_busA", busA, 32'hA5A5);
    check("byp_stall", stall, 1'b0);
`else
    check("nobyp_busA", busA, 32'h1111);
    check("nobyp_stall", stall, 1'b1);
`endif
    tick();
    idle();
    #1;
    check("wb4_busA", busA, 32'hA5A5);
    check("wb4_stall", stall, 1'b0);
    rs_rd = 1'b0;

    // Forwarding priority between the ports; r0 is never forwarded.
    rs = 5'd10; rt = 5'd0;
    we0 = 1'b1; wa0 = 5'd10; wd0 = 32'hAAAA;
    we1 = 1'b1; wa1 = 5'd10; wd1 = 32'hBBBB;
    #1;
`ifdef GPR_BYPASS_EN
    check("fwd_prio", busA, 32'hBBBB);
`else
    check("fwd_none", busA, 32'h0);
`endif
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hAAAA;
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hBBBB;
    #1;
    check("fwd_r0", busB, 32'h0);
    idle();
    pulse_clr();

    // Equality comparator.
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h42;
    tick();
    idle();
    rs = 5'd7; rt = 5'd7;
    #1;
    check("eq_same", eq, 1'b1);
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h99;
    rt = 5'd6;
    tick();
    idle();
    #1;
    check("eq_diff", eq, 1'b0);
    check("eq_r7", busA, 32'h99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
